// File: rtl/useq_sequencer.sv
// useq_sequencer: microcode sequencer driving the two-register datapath through dp_ctrl (optional single-step: USEQ_STEP_EN).
// Latency: first dp_ctrl word 1 cycle after start is accepted; one word per enabled cycle; done 1 cycle after HALT/abort.
// Backpressure: en (and step when USEQ_STEP_EN) low freezes pc/state/watchdog; dp_ctrl holds the current word (0 while step low).
module useq_sequencer #(
  parameter int P_LOG_MEMSIZE    = 4,
  parameter int P_NUM_D_CTRLBITS = 5,
  parameter int P_NUM_C_CTRLBITS = 2,
  parameter int P_MAX_CYCLES     = 1000
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    en,
`ifdef USEQ_STEP_EN
  input  logic                                                    step,
`endif
  input  logic                                                    start,
  input  logic [P_LOG_MEMSIZE-1:0]                                start_addr,
  input  logic                                                    cres,
  output logic [P_NUM_D_CTRLBITS-1:0]                             dp_ctrl,
  output logic                                                    busy,
  output logic                                                    done,
  output logic                                                    err,
  input  logic                                                    wr_en,
  input  logic [P_LOG_MEMSIZE-1:0]                                wr_addr,
  input  logic [P_NUM_D_CTRLBITS+P_NUM_C_CTRLBITS+P_LOG_MEMSIZE-1:0] wr_data
);

  localparam int W     = P_NUM_D_CTRLBITS + P_NUM_C_CTRLBITS + P_LOG_MEMSIZE;
  localparam int DEPTH = 1 << P_LOG_MEMSIZE;
  localparam int CNT_W = 16;

  // Field boundaries inside a microcode word {target, mode, dctl}.
  localparam int D_LSB = 0;
  localparam int M_LSB = P_NUM_D_CTRLBITS;
  localparam int T_LSB = P_NUM_D_CTRLBITS + P_NUM_C_CTRLBITS;

  localparam logic [P_NUM_C_CTRLBITS-1:0] MODE_SEQ  = P_NUM_C_CTRLBITS'(0);
  localparam logic [P_NUM_C_CTRLBITS-1:0] MODE_JMP  = P_NUM_C_CTRLBITS'(1);
  localparam logic [P_NUM_C_CTRLBITS-1:0] MODE_BRC  = P_NUM_C_CTRLBITS'(2);
  localparam logic [P_NUM_C_CTRLBITS-1:0] MODE_HALT = P_NUM_C_CTRLBITS'(3);

  localparam logic [P_LOG_MEMSIZE-1:0] PC_ONE    = P_LOG_MEMSIZE'(1);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]           MAX_WORDS = (CNT_W + 1)'(P_MAX_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Microcode store: deliberately not reset so contents survive rst_n.
  logic [W-1:0] mem [0:DEPTH-1];

  state_t                     state, state_nxt;
  logic [P_LOG_MEMSIZE-1:0]   pc, pc_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic                       done_nxt;
  logic                       err_nxt;

  logic [W-1:0]                cur_word;
  logic [P_NUM_D_CTRLBITS-1:0] cur_dctl;
  logic [P_NUM_C_CTRLBITS-1:0] cur_mode;
  logic [P_LOG_MEMSIZE-1:0]    cur_target;
  logic [P_LOG_MEMSIZE-1:0]    pc_inc;
  logic                        step_ok;
  logic                        exec;
  logic                        wd_hit;

  // Combinational read of the word at pc and its fields.
  assign cur_word   = mem[pc];
  assign cur_dctl   = cur_word[D_LSB +: P_NUM_D_CTRLBITS];
  assign cur_mode   = cur_word[M_LSB +: P_NUM_C_CTRLBITS];
  assign cur_target = cur_word[T_LSB +: P_LOG_MEMSIZE];
  assign pc_inc     = pc + PC_ONE;

`ifdef USEQ_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // A word executes only on an enabled (and stepped) RUN cycle.
  assign exec   = (state == S_RUN) && en && step_ok;
  // This execution would be word number P_MAX_CYCLES of the run.
  assign wd_hit = (({1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1}) == MAX_WORDS);

  assign busy = (state == S_RUN);

  // Microcode write port: only accepted while idle so a running program never changes under itself.
  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Datapath control: current word's dctl in RUN, zero for HALT, idle, or an unstepped cycle.
  always_comb begin
    dp_ctrl = '0;
    if ((state == S_RUN) && (cur_mode != MODE_HALT) && step_ok) begin
      dp_ctrl = cur_dctl;
    end
  end

  // Next-state, pc sequencing, watchdog and completion flags.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && start) begin
          state_nxt = S_RUN;
          pc_nxt    = start_addr;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      S_RUN: begin
        if (exec) begin
          cnt_nxt = cnt + CNT_ONE;
          if (cur_mode == MODE_HALT) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else if (wd_hit) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            case (cur_mode)
              MODE_SEQ: pc_nxt = pc_inc;
              MODE_JMP: pc_nxt = cur_target;
              MODE_BRC: pc_nxt = cres ? cur_target : pc_inc;
              default:  pc_nxt = pc;
            endcase
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State registers; done is a single-cycle pulse regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// tb_useq_sequencer: directed cycle-by-cycle vectors for useq_sequencer (watchdog limit 8).
// Latency: each vector drives inputs at the falling edge and checks outputs 1 time unit later.
// Backpressure: en is exercised as a stall; no other flow control.
module tb_useq_sequencer;

  localparam int L = 4;
  localparam int D = 5;
  localparam int C = 2;
  localparam int W = D + C + L;

  localparam logic [1:0] SEQ  = 2'd0;
  localparam logic [1:0] JMP  = 2'd1;
  localparam logic [1:0] BRC  = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         start;
  logic [L-1:0] start_addr;
  logic         cres;
  logic [D-1:0] dp_ctrl;
  logic         busy;
  logic         done;
  logic         err;
  logic         wr_en;
  logic [L-1:0] wr_addr;
  logic [W-1:0] wr_data;

  useq_sequencer #(
    .P_LOG_MEMSIZE   (L),
    .P_NUM_D_CTRLBITS(D),
    .P_NUM_C_CTRLBITS(C),
    .P_MAX_CYCLES    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .start_addr(start_addr),
    .cres      (cres),
    .dp_ctrl   (dp_ctrl),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct {
    logic         en;
    logic         start;
    logic [L-1:0] sa;
    logic         cres;
    logic         wr;
    logic [L-1:0] wa;
    logic [W-1:0] wd;
    logic [D-1:0] dp;
    logic         busy;
    logic         done;
    logic         err;
  } vec_t;

  vec_t tbl[$];
  logic cur_err;
  int   nvec;
  int   nbad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] mk(input logic [L-1:0] t, input logic [1:0] m, input logic [D-1:0] d);
    return {t, m, d};
  endfunction

  task automatic row(input logic e, input logic s, input logic [L-1:0] sa, input logic cr,
                     input logic w, input logic [L-1:0] wa, input logic [W-1:0] wd,
                     input logic [D-1:0] dp, input logic b, input logic dn);
    vec_t r;
    r.en = e; r.start = s; r.sa = sa; r.cres = cr;
    r.wr = w; r.wa = wa; r.wd = wd;
    r.dp = dp; r.busy = b; r.done = dn; r.err = cur_err;
    tbl.push_back(r);
  endtask

  task automatic t_wr(input logic [L-1:0] a, input logic [W-1:0] w);
    row(1'b1, 1'b0, '0, 1'b0, 1'b1, a, w, '0, 1'b0, 1'b0);
  endtask

  task automatic t_start(input logic [L-1:0] sa);
    row(1'b1, 1'b1, sa, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic t_run(input logic [D-1:0] dp, input logic cr);
    row(1'b1, 1'b0, '0, cr, 1'b0, '0, '0, dp, 1'b1, 1'b0);
  endtask

  task automatic t_done();
    row(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input int idx, input logic [D-1:0] act, input logic [D-1:0] exp);
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t r, input int idx);
    @(negedge clk);
    en = r.en; start = r.start; start_addr = r.sa; cres = r.cres;
    wr_en = r.wr; wr_addr = r.wa; wr_data = r.wd;
    #1;
    nvec++;
    chk("dp_ctrl", idx, dp_ctrl, r.dp);
    chk("busy", idx, {4'b0, busy}, {4'b0, r.busy});
    chk("done", idx, {4'b0, done}, {4'b0, r.done});
    chk("err", idx, {4'b0, err}, {4'b0, r.err});
  endtask

  initial begin
    nvec = 0; nbad = 0; cur_err = 1'b0;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; start_addr = '0; cres = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Program image.
    t_wr(4'd0, mk(4'd0, SEQ, 5'd1));
    t_wr(4'd1, mk(4'd0, HALT, 5'd21));
    t_wr(4'd2, mk(4'd5, BRC, 5'd2));
    t_wr(4'd3, mk(4'd0, SEQ, 5'd3));
    t_wr(4'd4, mk(4'd0, HALT, 5'd4));
    t_wr(4'd5, mk(4'd0, SEQ, 5'd5));
    t_wr(4'd6, mk(4'd0, HALT, 5'd6));
    t_wr(4'd7, mk(4'd7, JMP, 5'd7));
    for (int i = 8; i < 15; i++) t_wr(4'(i), mk(4'd0, SEQ, 5'(i)));
    t_wr(4'd15, mk(4'd0, SEQ, 5'd15));

    // Basic SEQ then HALT (HALT dctl nonzero but must show as 0).
    t_start(4'd0); t_run(5'd1, 1'b0); t_run(5'd0, 1'b0); t_done();
    // Branch taken, then not taken.
    t_start(4'd2); t_run(5'd2, 1'b1); t_run(5'd5, 1'b0); t_run(5'd0, 1'b0); t_done();
    t_start(4'd2); t_run(5'd2, 1'b0); t_run(5'd3, 1'b1); t_run(5'd0, 1'b0); t_done();
    // pc wrap 15 -> 0.
    t_start(4'd15); t_run(5'd15, 1'b0); t_run(5'd1, 1'b0); t_run(5'd0, 1'b0); t_done();
    // Watchdog abort on JMP self-loop; start during RUN ignored.
    t_start(4'd7);
    for (int i = 0; i < 8; i++) row(1'b1, (i == 3), 4'd0, 1'b0, 1'b0, '0, '0, 5'd7, 1'b1, 1'b0);
    cur_err = 1'b1;
    t_done();
    // Next start clears err.
    t_start(4'd0);
    cur_err = 1'b0;
    t_run(5'd1, 1'b0); t_run(5'd0, 1'b0); t_done();
    // Eighth word is HALT: completes normally without abort.
    t_wr(4'd15, mk(4'd0, HALT, 5'd15));
    t_start(4'd8);
    for (int i = 8; i < 15; i++) t_run(5'(i), 1'b0);
    t_run(5'd0, 1'b0); t_done();
    // en low for 3 cycles mid-run with writes attempted during RUN.
    t_start(4'd2); t_run(5'd2, 1'b0);
    row(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd3, mk(4'd0, SEQ, 5'd31), 5'd3, 1'b1, 1'b0);
    row(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 5'd3, 1'b1, 1'b0);
    row(1'b0, 1'b1, '0, 1'b0, 1'b0, '0, '0, 5'd3, 1'b1, 1'b0);
    row(1'b1, 1'b0, '0, 1'b0, 1'b1, 4'd4, mk(4'd0, SEQ, 5'd30), 5'd3, 1'b1, 1'b0);
    t_run(5'd0, 1'b0);
    // done clears after one cycle even with en low; start with en low ignored.
    row(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 5'd0, 1'b0, 1'b1);
    row(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, '0, '0, 5'd0, 1'b0, 1'b0);
    row(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 5'd0, 1'b0, 1'b0);
    // Memory untouched by RUN-time writes.
    t_start(4'd2); t_run(5'd2, 1'b0); t_run(5'd3, 1'b0); t_run(5'd0, 1'b0); t_done();
    // Write and start same cycle at the same address.
    row(1'b1, 1'b1, 4'd14, 1'b0, 1'b1, 4'd14, mk(4'd0, HALT, 5'd9), 5'd0, 1'b0, 1'b0);
    t_run(5'd0, 1'b0); t_done();

    // Reset state.
    #2;
    nvec++;
    chk("rst_dp_ctrl", -1, dp_ctrl, 5'd0);
    chk("rst_busy", -1, {4'b0, busy}, 5'd0);
    chk("rst_done", -1, {4'b0, done}, 5'd0);
    chk("rst_err", -1, {4'b0, err}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Asynchronous reset mid-run, then restart on retained microcode.
    tbl.delete();
    cur_err = 1'b0;
    t_start(4'd2); t_run(5'd2, 1'b1);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1000 + i);
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    chk("async_busy", 2000, {4'b0, busy}, 5'd0);
    chk("async_dp_ctrl", 2000, dp_ctrl, 5'd0);
    chk("async_done", 2000, {4'b0, done}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tbl.delete();
    t_start(4'd2); t_run(5'd2, 1'b1); t_run(5'd5, 1'b0); t_run(5'd0, 1'b0); t_done();
    t_start(4'd0); t_run(5'd1, 1'b0); t_run(5'd0, 1'b0); t_done();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 3000 + i);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
